// File: rtl/transform_pkg.sv
// rtl/transform_pkg.sv - shared types, board vertex constants and FSM encoding
package transform_pkg;

  localparam int COORD_W = 11;

  typedef logic signed [COORD_W-1:0] coord_t;

  // Board square corners: (LO,LO) (HI,LO) (HI,HI) (LO,HI)
  localparam coord_t BOARD_LO = 11'sd100;
  localparam coord_t BOARD_HI = 11'sd300;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_ISSUE = 3'd2,
    S_DRAIN = 3'd3,
    S_SWAP  = 3'd4
  } state_t;

endpackage

// File: rtl/transform_sequencer_if.sv
// rtl/transform_sequencer_if.sv - sequencer <-> transform_mapping bus
interface transform_sequencer_if;

  transform_pkg::coord_t map_sin_x;
  transform_pkg::coord_t map_sin_y;
  transform_pkg::coord_t map_x;
  transform_pkg::coord_t map_y;
  transform_pkg::coord_t map_x_out;
  transform_pkg::coord_t map_y_out;

  modport master (
    output map_sin_x, map_sin_y, map_x, map_y,
    input  map_x_out, map_y_out
  );

  modport slave (
    input  map_sin_x, map_sin_y, map_x, map_y,
    output map_x_out, map_y_out
  );

endinterface

// File: rtl/transform_sequencer_vertex_rom.sv
// rtl/transform_sequencer_vertex_rom.sv - combinational board vertex lookup
module vertex_rom
  import transform_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic [IDX_W-1:0] idx,
  output coord_t           x,
  output coord_t           y
);

  // Fixed board corners; any other index reads as the origin
  always_comb begin
    x = '0;
    y = '0;
    case (idx)
      IDX_W'(0): begin x = BOARD_LO; y = BOARD_LO; end
      IDX_W'(1): begin x = BOARD_HI; y = BOARD_LO; end
      IDX_W'(2): begin x = BOARD_HI; y = BOARD_HI; end
      IDX_W'(3): begin x = BOARD_LO; y = BOARD_HI; end
      default:   begin x = '0;       y = '0;       end
    endcase
  end

endmodule

// File: rtl/transform_sequencer.sv
// rtl/transform_sequencer.sv - frame sequencer feeding transform_mapping into a double-buffered table
module transform_sequencer
  import transform_pkg::*;
#(
  parameter int N_POINTS  = 5,
  parameter int XFORM_LAT = 2,
  parameter int IDX_W     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  coord_t                tilt_sin_x,
  input  coord_t                tilt_sin_y,
  input  coord_t                ball_x,
  input  coord_t                ball_y,
  transform_sequencer_if.master map,
  input  logic [IDX_W-1:0]      rd_idx,
  output coord_t                rd_x,
  output coord_t                rd_y,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  state_t                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  coord_t                          sin_x_q, sin_x_d, sin_y_q, sin_y_d;
  coord_t                          ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  coord_t                          map_x_q, map_x_d, map_y_q, map_y_d;
  logic                            disp_q, disp_d;
  logic                            done_q, done_d, ovr_q, ovr_d;
  logic [XFORM_LAT-1:0]            tag_vld_q, tag_vld_d;
  logic [XFORM_LAT-1:0][IDX_W-1:0] tag_idx_q, tag_idx_d;
  coord_t                          bank_x_q [2][N_POINTS];
  coord_t                          bank_x_d [2][N_POINTS];
  coord_t                          bank_y_q [2][N_POINTS];
  coord_t                          bank_y_d [2][N_POINTS];
  coord_t                          rd_x_q, rd_x_d, rd_y_q, rd_y_d;
  coord_t                          rom_x, rom_y;
  logic [IDX_W-1:0]                wr_idx;

  vertex_rom #(.IDX_W(IDX_W)) u_rom (
    .idx (idx_q),
    .x   (rom_x),
    .y   (rom_y)
  );

  // Frame FSM: next state, operand snapshot, vertex/drain counter, bank flip
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sin_x_d  = sin_x_q;
    sin_y_d  = sin_y_q;
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    disp_d   = disp_q;
    done_d   = 1'b0;
    ovr_d    = frame_start && (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (frame_start) state_d = S_LATCH;
      end
      S_LATCH: begin
        sin_x_d  = tilt_sin_x;
        sin_y_d  = tilt_sin_y;
        ball_x_d = ball_x;
        ball_y_d = ball_y;
        idx_d    = '0;
        state_d  = S_ISSUE;
      end
      S_ISSUE: begin
        if (idx_q == IDX_W'(N_POINTS - 1)) begin
          idx_d   = '0;
          state_d = S_DRAIN;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DRAIN: begin
        // idx doubles as the drain counter once issuing is over
        if (idx_q == IDX_W'(XFORM_LAT - 1)) state_d = S_SWAP;
        else                                idx_d   = idx_q + IDX_W'(1);
      end
      S_SWAP: begin
        disp_d  = ~disp_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Vertex issue, result tag pipe, work-bank capture and display-bank read
  always_comb begin
    map_x_d = map_x_q;
    map_y_d = map_y_q;
    if (state_q == S_ISSUE) begin
      if (idx_q == IDX_W'(N_POINTS - 1)) begin
        map_x_d = ball_x_q;
        map_y_d = ball_y_q;
      end else begin
        map_x_d = rom_x;
        map_y_d = rom_y;
      end
    end

    tag_vld_d    = '0;
    tag_idx_d    = '0;
    tag_vld_d[0] = (state_q == S_ISSUE);
    tag_idx_d[0] = idx_q;
    for (int i = 1; i < XFORM_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_idx_d[i] = tag_idx_q[i-1];
    end

    bank_x_d = bank_x_q;
    bank_y_d = bank_y_q;
    wr_idx   = tag_idx_q[XFORM_LAT-1];
    if (tag_vld_q[XFORM_LAT-1] && ({1'b0, wr_idx} < (IDX_W+1)'(N_POINTS))) begin
      bank_x_d[~disp_q][wr_idx] = map.map_x_out;
      bank_y_d[~disp_q][wr_idx] = map.map_y_out;
    end

    // Read through the bank selected after this edge so done and new data coincide
    rd_x_d = '0;
    rd_y_d = '0;
    if ({1'b0, rd_idx} < (IDX_W+1)'(N_POINTS)) begin
      rd_x_d = bank_x_q[disp_d][rd_idx];
      rd_y_d = bank_y_q[disp_d][rd_idx];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers; reset also discards any partially written work bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      sin_x_q   <= '0;
      sin_y_q   <= '0;
      ball_x_q  <= '0;
      ball_y_q  <= '0;
      map_x_q   <= '0;
      map_y_q   <= '0;
      disp_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      tag_vld_q <= '0;
      tag_idx_q <= '0;
      rd_x_q    <= '0;
      rd_y_q    <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N_POINTS; i++) begin
          bank_x_q[b][i] <= '0;
          bank_y_q[b][i] <= '0;
        end
      end
    end else begin
      idx_q     <= idx_d;
      sin_x_q   <= sin_x_d;
      sin_y_q   <= sin_y_d;
      ball_x_q  <= ball_x_d;
      ball_y_q  <= ball_y_d;
      map_x_q   <= map_x_d;
      map_y_q   <= map_y_d;
      disp_q    <= disp_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
      tag_vld_q <= tag_vld_d;
      tag_idx_q <= tag_idx_d;
      rd_x_q    <= rd_x_d;
      rd_y_q    <= rd_y_d;
      bank_x_q  <= bank_x_d;
      bank_y_q  <= bank_y_d;
    end
  end

  assign map.map_sin_x = sin_x_q;
  assign map.map_sin_y = sin_y_q;
  assign map.map_x     = map_x_d;
  assign map.map_y     = map_y_d;
  assign rd_x          = rd_x_q;
  assign rd_y          = rd_y_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign overrun       = ovr_q;

endmodule
